// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//   Input stage for the game control unit. Synchronises the nine raw cell
//   buttons, debounces a single pressed button and emits a one-cycle move
//   pulse with the registered cell index. All buttons must be released and
//   stay released for the debounce interval before the next move is accepted.
//
// Optional feature (macro DETECTOR_MASCARA_EN):
//   Adds input `mascara` (1 = cell not playable) and output
//   `jogada_rejeitada`. A debounced press on a masked cell produces a
//   one-cycle `jogada_rejeitada` pulse instead of `tem_jogada`, and `jogada`
//   keeps its previous value.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous reset, active low
//   habilita         in   high while the control unit waits for a move
//   botoes           in   raw button levels, 1 = pressed
//   mascara          in   (macro only) occupied / unplayable cells
//   jogada_rejeitada out  (macro only) one-cycle pulse: masked move refused
//   tem_jogada       out  one-cycle pulse: valid move on `jogada`
//   jogada           out  registered index of the accepted button (0-8)
//   db_estado        out  FSM state code (7 while in an illegal code)
// -----------------------------------------------------------------------------
module detector_jogada #(
  parameter int N_BOTOES        = 9,
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
`ifdef DETECTOR_MASCARA_EN
  input  logic [N_BOTOES-1:0] mascara,
  output logic                jogada_rejeitada,
`endif
  output logic                tem_jogada,
  output logic [3:0]          jogada,
  output logic [2:0]          db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  localparam logic [2:0] ESPERA         = 3'd0;
  localparam logic [2:0] FILTRA         = 3'd1;
  localparam logic [2:0] CONFIRMA       = 3'd2;
  localparam logic [2:0] AGUARDA_SOLTAR = 3'd3;

  // Exactly one bit set.
  function automatic logic f_unico(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Position of the set bit of a one-hot pattern.
  function automatic logic [3:0] f_indice(input logic [N_BOTOES-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [N_BOTOES-1:0] r_sinc1;
  logic [N_BOTOES-1:0] r_bs;
  logic [N_BOTOES-1:0] r_cap;
  logic [2:0]          r_estado;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_jogada;

  logic [2:0]          w_estado_prox;
  logic [CNT_W-1:0]    w_cnt_prox;
  logic                w_cap_carrega;
  logic                w_jog_carrega;
  logic                w_mascarado;

`ifdef DETECTOR_MASCARA_EN
  logic r_rej;
  logic w_rej_prox;
  // The mask is looked at only at the moment of confirmation.
  assign w_mascarado = |(mascara & r_cap);
`else
  assign w_mascarado = 1'b0;
`endif

  // Two-flop synchroniser; the FSM only ever sees r_bs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= '0;
      r_bs    <= '0;
    end else begin
      r_sinc1 <= botoes;
      r_bs    <= r_sinc1;
    end
  end

  // State register plus the datapath registers steered by the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= AGUARDA_SOLTAR;
      r_cnt    <= '0;
      r_cap    <= '0;
      r_jogada <= 4'd0;
`ifdef DETECTOR_MASCARA_EN
      r_rej    <= 1'b0;
`endif
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      if (w_cap_carrega) r_cap <= r_bs;
      if (w_jog_carrega) r_jogada <= f_indice(r_cap);
`ifdef DETECTOR_MASCARA_EN
      r_rej    <= w_rej_prox;
`endif
    end
  end

  // Next-state logic. Every increment is guarded by a compare against
  // CNT_MAX, so the counter saturates and never wraps.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_cap_carrega = 1'b0;
    w_jog_carrega = 1'b0;
`ifdef DETECTOR_MASCARA_EN
    w_rej_prox    = r_rej;
`endif
    case (r_estado)
      ESPERA: begin
        if (habilita && f_unico(r_bs)) begin
          w_estado_prox = FILTRA;
          w_cnt_prox    = '0;
          w_cap_carrega = 1'b1;
        end
      end
      FILTRA: begin
        // Losing habilita takes priority over a confirm in the same cycle.
        if (!habilita) begin
          w_estado_prox = ESPERA;
        end else if (r_bs != r_cap) begin
          w_estado_prox = (r_bs == '0) ? ESPERA : AGUARDA_SOLTAR;
        end else if (r_cnt == CNT_MAX) begin
          w_estado_prox = CONFIRMA;
          w_jog_carrega = !w_mascarado;
`ifdef DETECTOR_MASCARA_EN
          w_rej_prox    = w_mascarado;
`endif
        end else begin
          w_cnt_prox = r_cnt + 1'b1;
        end
      end
      CONFIRMA: begin
        w_estado_prox = AGUARDA_SOLTAR;
        w_cnt_prox    = '0;
      end
      AGUARDA_SOLTAR: begin
        // Any activity restarts the release window; habilita is ignored.
        if (r_bs != '0) begin
          w_cnt_prox = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_estado_prox = ESPERA;
          w_cnt_prox    = '0;
        end else begin
          w_cnt_prox = r_cnt + 1'b1;
        end
      end
      default: begin
        w_estado_prox = AGUARDA_SOLTAR;
        w_cnt_prox    = '0;
      end
    endcase
  end

  // Moore outputs.
  always_comb begin
    tem_jogada = 1'b0;
    db_estado  = r_estado;
`ifdef DETECTOR_MASCARA_EN
    jogada_rejeitada = 1'b0;
`endif
    case (r_estado)
      ESPERA, FILTRA, AGUARDA_SOLTAR: ;
      CONFIRMA: begin
`ifdef DETECTOR_MASCARA_EN
        tem_jogada       = !r_rej;
        jogada_rejeitada = r_rej;
`else
        tem_jogada = 1'b1;
`endif
      end
      default: db_estado = 3'd7;
    endcase
  end

  assign jogada = r_jogada;

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [8:0] botoes = 9'd0;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic [2:0] db_estado;
`ifdef DETECTOR_MASCARA_EN
  logic [8:0] mascara = 9'd0;
  logic       jogada_rejeitada;
`endif

  int checks = 0;
  int failures = 0;

  int n_tem = 0;
  int n_rej = 0;
  int n_dbl = 0;
  logic tem_ant = 1'b0;

  detector_jogada #(.N_BOTOES(9), .DEBOUNCE_CICLOS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .habilita         (habilita),
    .botoes           (botoes),
`ifdef DETECTOR_MASCARA_EN
    .mascara          (mascara),
    .jogada_rejeitada (jogada_rejeitada),
`endif
    .tem_jogada       (tem_jogada),
    .jogada           (jogada),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clock) begin
    if (tem_jogada) n_tem = n_tem + 1;
    if (tem_jogada && tem_ant) n_dbl = n_dbl + 1;
    tem_ant = tem_jogada;
`ifdef DETECTOR_MASCARA_EN
    if (jogada_rejeitada) n_rej = n_rej + 1;
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    botoes = 9'd0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; habilita = 1'b0; botoes = 9'd0;
    repeat (2) tick();
    checks++; if (tem_jogada !== 1'b0) begin failures++; $display("FAIL reset_tem got=%b exp=0", tem_jogada); end
    checks++; if (jogada !== 4'd0) begin failures++; $display("FAIL reset_jogada got=%0d exp=0", jogada); end
    checks++; if (db_estado !== 3'd3) begin failures++; $display("FAIL reset_estado got=%0d exp=3", db_estado); end
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (db_estado !== 3'd3) begin failures++; $display("FAIL settle3_estado got=%0d exp=3", db_estado); end
    tick();
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL settle4_estado got=%0d exp=0", db_estado); end
  endtask

  task automatic test_accept();
    logic [2:0] exp_db;
    int t0;
    t0 = n_tem;
    habilita = 1'b1;
    botoes = 9'b000010000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_db = (i <= 2) ? 3'd0 : (i <= 6) ? 3'd1 : (i == 7) ? 3'd2 : 3'd3;
      checks++; if (db_estado !== exp_db) begin failures++; $display("FAIL accept_estado edge=%0d got=%0d exp=%0d", i, db_estado, exp_db); end
      checks++; if (tem_jogada !== (i == 7)) begin failures++; $display("FAIL accept_tem edge=%0d got=%b exp=%b", i, tem_jogada, (i == 7)); end
      if (i == 7) begin
        checks++; if (jogada !== 4'd4) begin failures++; $display("FAIL accept_jogada got=%0d exp=4", jogada); end
      end
    end
    settle();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL accept_pulses got=%0d exp=1", n_tem - t0); end
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL accept_back_espera got=%0d exp=0", db_estado); end
  endtask

  task automatic test_bounce();
    int t0;
    t0 = n_tem;
    habilita = 1'b1;
    for (int i = 0; i < 20; i++) begin
      botoes = ((i / 2) % 2 == 0) ? 9'b000000001 : 9'd0;
      tick();
    end
    botoes = 9'd0;
    repeat (4) tick();
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", n_tem - t0); end
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL bounce_estado got=%0d exp=0", db_estado); end
    checks++; if (jogada !== 4'd4) begin failures++; $display("FAIL bounce_jogada got=%0d exp=4", jogada); end
  endtask

  task automatic test_multi();
    int t0;
    t0 = n_tem;
    habilita = 1'b1;
    botoes = 9'b000000101;
    repeat (20) tick();
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL multi_estado got=%0d exp=0", db_estado); end
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", n_tem - t0); end
    botoes = 9'd0;
    repeat (2) tick();
    botoes = 9'b100000000;
    repeat (10) tick();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL multi_cell8_pulses got=%0d exp=1", n_tem - t0); end
    checks++; if (jogada !== 4'd8) begin failures++; $display("FAIL multi_cell8_jogada got=%0d exp=8", jogada); end
    settle();
  endtask

  task automatic test_hold_disable();
    int t0;
    // Button held through reset, then released.
    t0 = n_tem;
    habilita = 1'b1;
    botoes = 9'b000001000;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    settle();
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL held_reset_pulses got=%0d exp=0", n_tem - t0); end
    checks++; if (jogada !== 4'd0) begin failures++; $display("FAIL held_reset_jogada got=%0d exp=0", jogada); end
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL held_reset_estado got=%0d exp=0", db_estado); end
    // Long hold: one pulse only.
    t0 = n_tem;
    botoes = 9'b000000010;
    repeat (50) tick();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL hold50_pulses got=%0d exp=1", n_tem - t0); end
    checks++; if (jogada !== 4'd1) begin failures++; $display("FAIL hold50_jogada got=%0d exp=1", jogada); end
    settle();
    // habilita dropped in the middle of FILTRA.
    t0 = n_tem;
    botoes = 9'b001000000;
    repeat (4) tick();
    checks++; if (db_estado !== 3'd1) begin failures++; $display("FAIL mid_filtra_estado got=%0d exp=1", db_estado); end
    habilita = 1'b0;
    tick();
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL abort_estado got=%0d exp=0", db_estado); end
    repeat (10) tick();
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", n_tem - t0); end
    settle();
    // habilita drops on the very edge that would confirm: abort wins.
    habilita = 1'b1;
    t0 = n_tem;
    botoes = 9'b000000100;
    repeat (6) tick();
    habilita = 1'b0;
    tick();
    checks++; if (tem_jogada !== 1'b0) begin failures++; $display("FAIL confirm_abort_tem got=%b exp=0", tem_jogada); end
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL confirm_abort_estado got=%0d exp=0", db_estado); end
    settle();
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL confirm_abort_pulses got=%0d exp=0", n_tem - t0); end
    checks++; if (jogada !== 4'd1) begin failures++; $display("FAIL confirm_abort_jogada got=%0d exp=1", jogada); end
    habilita = 1'b1;
  endtask

  task automatic test_release();
    int t0;
    t0 = n_tem;
    habilita = 1'b1;
    botoes = 9'b000100000;
    repeat (10) tick();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL release_first_pulses got=%0d exp=1", n_tem - t0); end
    botoes = 9'd0;
    repeat (2) tick();
    botoes = 9'b000100000;
    repeat (12) tick();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL release_short_pulses got=%0d exp=1", n_tem - t0); end
    checks++; if (db_estado !== 3'd3) begin failures++; $display("FAIL release_short_estado got=%0d exp=3", db_estado); end
    settle();
    botoes = 9'b000100000;
    repeat (10) tick();
    checks++; if (n_tem - t0 !== 2) begin failures++; $display("FAIL release_full_pulses got=%0d exp=2", n_tem - t0); end
    checks++; if (jogada !== 4'd5) begin failures++; $display("FAIL release_full_jogada got=%0d exp=5", jogada); end
    settle();
    checks++; if (n_dbl !== 0) begin failures++; $display("FAIL consecutive_pulses got=%0d exp=0", n_dbl); end
  endtask

`ifdef DETECTOR_MASCARA_EN
  task automatic test_mascara();
    int t0;
    int r0;
    t0 = n_tem;
    r0 = n_rej;
    habilita = 1'b1;
    mascara = 9'b000000100;
    botoes = 9'b000000100;
    repeat (10) tick();
    checks++; if (n_rej - r0 !== 1) begin failures++; $display("FAIL mask_rej_pulses got=%0d exp=1", n_rej - r0); end
    checks++; if (n_tem - t0 !== 0) begin failures++; $display("FAIL mask_tem_pulses got=%0d exp=0", n_tem - t0); end
    checks++; if (jogada !== 4'd5) begin failures++; $display("FAIL mask_jogada got=%0d exp=5", jogada); end
    settle();
    botoes = 9'b000001000;
    repeat (10) tick();
    checks++; if (n_tem - t0 !== 1) begin failures++; $display("FAIL mask_free_pulses got=%0d exp=1", n_tem - t0); end
    checks++; if (n_rej - r0 !== 1) begin failures++; $display("FAIL mask_free_rej got=%0d exp=1", n_rej - r0); end
    checks++; if (jogada !== 4'd3) begin failures++; $display("FAIL mask_free_jogada got=%0d exp=3", jogada); end
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_accept();
    test_bounce();
    test_multi();
    test_hold_disable();
    test_release();
`ifdef DETECTOR_MASCARA_EN
    test_mascara();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Upstream input stage for the game control unit. Turns the 9 raw cell buttons into one clean move.
- Synchronises and debounces the buttons, and accepts only a single pressed button.
- Emits a one-cycle `tem_jogada` pulse with a registered cell index (`jogada`, 0-8). The control unit consumes this in its macro and micro play states.
- Requires full release of all buttons before it accepts the next move.

Parameters:
- N_BOTOES, 9, number of cell buttons; `botoes` width. Fixed at 9 for the 3x3 board.
- DEBOUNCE_CICLOS, 1000, consecutive stable cycles required to confirm a press and to confirm a release. Must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilita  in  1  high while the control unit waits for a move (its jogar_macro OR jogar_micro).
- botoes  in  N_BOTOES  raw, asynchronous button levels; 1 = pressed.
- tem_jogada  out  1  one-cycle pulse: a valid move is available on `jogada`.
- jogada  out  4  registered index of the accepted button, 0-8; holds its value until the next accept.
- db_estado  out  3  current FSM state code, for debug.

Behaviour:
- Input synchroniser:
  - `botoes` passes through a 2-flop synchroniser; `bs` is the second stage.
  - The FSM sees only `bs`.
- Asynchronous reset (reset=0):
  - state = AGUARDA_SOLTAR; counter = 0; sync flops = 0.
  - jogada = 4'd0; tem_jogada = 0; db_estado = 3'd3.
  - Starting in AGUARDA_SOLTAR means a button held through reset is never accepted.
- "single" means `bs` has exactly one bit set; `idx` is that bit's position (0-8).
- FSM states and codes (Moore outputs):
  - ESPERA (0):
    - `habilita`=1 and `bs` single -> capture the pattern into `cap`, counter := 0, go to FILTRA.
    - Zero bits or two or more bits set -> stay.
    - `habilita`=0 -> stay.
  - FILTRA (1):
    - `habilita`=0 -> ESPERA.
    - `bs` != `cap` -> if `bs`==0 go to ESPERA, else go to AGUARDA_SOLTAR.
    - `bs`==`cap` and counter == DEBOUNCE_CICLOS-1 -> CONFIRMA.
    - Otherwise counter += 1.
  - CONFIRMA (2):
    - Lasts exactly one cycle; tem_jogada = 1.
    - `jogada` is loaded with idx(`cap`) on entry, so it is valid in the same cycle as the pulse.
    - Unconditionally goes to AGUARDA_SOLTAR with counter := 0.
  - AGUARDA_SOLTAR (3):
    - `bs`!=0 -> counter := 0.
    - `bs`==0 -> counter += 1.
    - Counter == DEBOUNCE_CICLOS-1 with `bs`==0 -> ESPERA.
    - `habilita` is ignored in this state.
- Unused state codes 4-7 recover to AGUARDA_SOLTAR; db_estado = 3'd7 while in an illegal code.
- Latency:
  - Count the rising edge that first samples a stable single press as edge 1.
  - tem_jogada is high in the cycle after edge DEBOUNCE_CICLOS+3.
- Pulse rules:
  - tem_jogada is never high for 2 consecutive cycles.
  - At most one pulse is emitted per press/release cycle.
- Counter:
  - Width = clog2(DEBOUNCE_CICLOS).
  - Saturates at DEBOUNCE_CICLOS-1 and never wraps.
- Simultaneous events: if `habilita` falls in the same cycle a FILTRA confirm would occur, the abort wins and no pulse is emitted.
- `habilita` falling during CONFIRMA does not cancel the pulse; the control unit ignores it outside its play states.

Optional Feature:
- Macro: DETECTOR_MASCARA_EN.
- Defined:
  - Adds input `mascara` [N_BOTOES-1:0], where 1 = cell occupied or not playable.
  - Adds output `jogada_rejeitada` (1 bit, reset 0).
  - In ESPERA, a single press on a masked cell behaves as a normal press through debounce.
  - At the confirm point, a masked cell goes to CONFIRMA with `jogada_rejeitada`=1 for one cycle instead of tem_jogada.
  - On a rejected move, `jogada` is not updated.
  - `mascara` is sampled at the confirm cycle.
- Undefined: no `mascara` or `jogada_rejeitada` ports; every debounced single press is accepted.

Test Plan:
- Press acceptance (DEBOUNCE_CICLOS=4): reset, wait for release-settle, habilita=1, botoes=9'b000010000 held -> tem_jogada=1 for exactly one cycle after edge 7, jogada=4'd4, db_estado sequence 0,1,2,3.
- Bounce rejection: botoes toggles 9'b1 / 0 every 2 cycles for 20 cycles -> tem_jogada never asserts, state returns to ESPERA, jogada unchanged.
- Multiple buttons: botoes=9'b000000101 held 20 cycles -> no pulse, state stays 0. Then release and press 9'b100000000 -> pulse, jogada=4'd8.
- Hold and disable:
  - Button held through reset then released -> no pulse.
  - Press held 50 cycles -> exactly one pulse.
  - habilita=0 mid-FILTRA -> no pulse, state 0.
- Release requirement: after an accept, re-press the same button 2 cycles after release (< DEBOUNCE_CICLOS) -> no second pulse. A full release of >= 4 cycles, then a new press -> second pulse.
- With DETECTOR_MASCARA_EN: mascara=9'b000000100, press cell 2 -> jogada_rejeitada pulse, tem_jogada=0, jogada keeps its previous value. Press cell 3 -> tem_jogada, jogada=4'd3.
